uart_rx_framer: RTL and testbench
=================================

Name: uart_rx_framer

Overview:
- Receive framing FSM of the APB UART; consumes the per-bit majority-vote result of the RX filter stage and drives that filter's SAMPLE/CLEAR.
- Detects start bit, shifts 5–8 data bits LSB first, checks optional parity and one stop bit.
- Delivers the character plus PE/FE/BI flags to the RX FIFO and LSR logic with a one-cycle strobe.

Parameters:
- OVERSAMPLE, 16, BAUDCE ticks per bit period; bit decision taken on tick OVERSAMPLE-1.
- CNT_W, 4, width of the tick counter; must hold OVERSAMPLE-1.

Ports:
- CLK  in  1  system clock
- RSTN  in  1  asynchronous active-low reset
- BAUDCE  in  1  oversample tick, one CLK wide, 16x baud
- RXD_RAW  in  1  synchronised serial input, used only for start-edge detection
- RXD_VOTE  in  1  filter output; 1 = majority of current bit period high
- FILTER_SAMPLE  out  1  filter sample enable
- FILTER_CLEAR  out  1  filter clear pulse
- WLS  in  2  word length: 00=5, 01=6, 10=7, 11=8
- PEN  in  1  parity enable
- EPS  in  1  even parity select
- SP  in  1  stick parity
- RXDAT  out  8  received character, unused MSBs zero
- RXPE  out  1  parity error
- RXFE  out  1  framing error
- RXBI  out  1  break indication
- RXFINISHED  out  1  one-CLK strobe; RXDAT and flags valid

Behaviour:
- Reset: state IDLE, tick counter 0, shift register 0. RXDAT=0, RXPE=RXFE=RXBI=0, RXFINISHED=0, FILTER_CLEAR=0, FILTER_SAMPLE=0.
- Reset is asynchronous. Assertion mid-frame aborts the frame immediately with no RXFINISHED.
- States: IDLE, START, DATA, PAR, STOP.
- FILTER_SAMPLE = BAUDCE when state != IDLE, else 0.
- Tick counter advances only on BAUDCE. At OVERSAMPLE-1 the counter wraps to 0 and is the "bit end" event.
- On every bit end: FILTER_CLEAR=1 for that cycle, and the bit value is RXD_VOTE sampled in that same cycle.
- IDLE:
  - On BAUDCE with RXD_RAW=0: go to START, counter 0, FILTER_CLEAR=1.
  - Latch WLS/PEN/EPS/SP here; later changes have no effect on the current frame.
- START, at bit end:
  - Vote 1 → false start, return to IDLE, no strobe.
  - Vote 0 → go to DATA, bit index 0.
- DATA, at bit end:
  - Shift the vote into bit [index].
  - After bit 4+WLS: go to PAR if PEN=1, else STOP.
- PAR, at bit end, expected parity:
  - SP=1: expected = ~EPS.
  - SP=0, EPS=1: expected = XOR of data bits.
  - SP=0, EPS=0: expected = inverted XOR of data bits.
  - Mismatch sets the pending PE. Then go to STOP.
- STOP, at bit end:
  - FE = ~vote.
  - BI = 1 when all data bits, parity bit (if enabled) and stop vote are 0.
  - Drive RXDAT/RXPE/RXFE/RXBI and RXFINISHED=1 for exactly one CLK, then go to IDLE.
- Outputs RXDAT/flags hold their values until the next RXFINISHED.
- Only one stop bit is checked. A second stop bit is treated as idle line.
- After a frame with FE or BI, IDLE re-arms immediately. If RXD_RAW is still 0 at the next BAUDCE, a new START begins; the FIFO side handles break filtering.
- BAUDCE held 0: FSM freezes, no timeout.
- BAUDCE and bit end in the same cycle as a state change: exactly one transition per bit end.

Decomposition:
- Shared uart package holds:
  - the state enum (rx_state_t);
  - WLS encodings (WLS_5..WLS_8);
  - the OVERSAMPLE default constant.
- Optional sub-module uart_rx_parity: combinational parity of an 8-bit masked word with WLS/EPS/SP. All other logic is flat in one module.

Test Plan:
- 8N1, byte 0xA5 at 16x ticks with the filter model → one RXFINISHED; RXDAT=0xA5, PE=FE=BI=0, strobe 160 ticks after start edge (±1 tick).
- 5E1 (WLS=00, PEN=1, EPS=1), data 0x13 with wrong parity bit 0 → RXDAT=0x13, RXPE=1, RXFE=0.
- 8N1, stop bit driven low, data 0x00 → RXDAT=0x00, RXFE=1, RXBI=1. The next BAUDCE with RXD_RAW low re-enters START.
- 4-tick low glitch on RXD_RAW, vote stays 1 → return to IDLE after 16 ticks; no RXFINISHED; FILTER_CLEAR pulsed twice (entry and bit end).
- Stick parity SP=1, EPS=0, 7-bit 0x55 with parity bit 1 → RXPE=0; parity bit 0 → RXPE=1.
- RSTN low at data bit 3 of 0xFF → all outputs 0 asynchronously. After release, a clean 0x3C frame is received correctly. WLS changed mid-frame → no effect until the next frame.

Source files
------------

// File: rtl/uart_rx_framer_pkg.sv
// uart_rx_framer_pkg: shared UART receive types, word-length encodings and defaults
package uart_rx_framer_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } rx_state_t;

    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    localparam int OVERSAMPLE_DEF = 16;

    function automatic logic [7:0] wls_mask(input logic [1:0] wls);
        return 8'hFF >> (3'd3 - {1'b0, wls});
    endfunction
endpackage

// File: rtl/uart_rx_framer_parity.sv
// uart_rx_framer_parity: expected parity bit for a received word under WLS/EPS/SP
module uart_rx_framer_parity
    import uart_rx_framer_pkg::*;
(
    input  logic [7:0] data,
    input  logic [1:0] wls,
    input  logic       eps,
    input  logic       sp,
    output logic       par
);
    logic x;

    assign x   = ^(data & wls_mask(wls));
    assign par = sp ? ~eps : (eps ? x : ~x);
endmodule

// File: rtl/uart_rx_framer.sv
// uart_rx_framer: receive framing FSM; start detect, 5-8 data bits LSB first,
// optional parity, one stop bit, and a one-cycle result strobe with PE/FE/BI.
module uart_rx_framer
    import uart_rx_framer_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int CNT_W      = 4
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       BAUDCE,
    input  logic       RXD_RAW,
    input  logic       RXD_VOTE,
    output logic       FILTER_SAMPLE,
    output logic       FILTER_CLEAR,
    input  logic [1:0] WLS,
    input  logic       PEN,
    input  logic       EPS,
    input  logic       SP,
    output logic [7:0] RXDAT,
    output logic       RXPE,
    output logic       RXFE,
    output logic       RXBI,
    output logic       RXFINISHED
);
    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       shreg;
    logic [1:0]       wls_q;
    logic             pen_q;
    logic             eps_q;
    logic             sp_q;
    logic             pe_pend;
    logic             par_bit;
    logic             bit_end;
    logic             start_det;
    logic             exp_par;

    assign bit_end       = BAUDCE && state != ST_IDLE && cnt == CNT_W'(OVERSAMPLE - 1);
    assign start_det     = BAUDCE && state == ST_IDLE && !RXD_RAW;
    assign FILTER_SAMPLE = BAUDCE && state != ST_IDLE;
    // Gated so the filter sees no clear while the block is held in reset
    assign FILTER_CLEAR  = RSTN && (bit_end || start_det);

    uart_rx_framer_parity u_par (
        .data(shreg),
        .wls (wls_q),
        .eps (eps_q),
        .sp  (sp_q),
        .par (exp_par)
    );

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            wls_q      <= '0;
            pen_q      <= 1'b0;
            eps_q      <= 1'b0;
            sp_q       <= 1'b0;
            pe_pend    <= 1'b0;
            par_bit    <= 1'b0;
            RXDAT      <= '0;
            RXPE       <= 1'b0;
            RXFE       <= 1'b0;
            RXBI       <= 1'b0;
            RXFINISHED <= 1'b0;
        end else begin
            RXFINISHED <= 1'b0;
            if (BAUDCE && state != ST_IDLE)
                cnt <= bit_end ? '0 : cnt + CNT_W'(1);
            case (state)
                ST_IDLE: if (start_det) begin
                    state   <= ST_START;
                    cnt     <= '0;
                    idx     <= '0;
                    shreg   <= '0;
                    pe_pend <= 1'b0;
                    par_bit <= 1'b0;
                    wls_q   <= WLS;
                    pen_q   <= PEN;
                    eps_q   <= EPS;
                    sp_q    <= SP;
                end
                ST_START: if (bit_end)
                    state <= RXD_VOTE ? ST_IDLE : ST_DATA;
                ST_DATA: if (bit_end) begin
                    shreg[idx] <= RXD_VOTE;
                    idx        <= idx + 3'd1;
                    if (idx == 3'd4 + {1'b0, wls_q})
                        state <= pen_q ? ST_PAR : ST_STOP;
                end
                ST_PAR: if (bit_end) begin
                    par_bit <= RXD_VOTE;
                    pe_pend <= RXD_VOTE != exp_par;
                    state   <= ST_STOP;
                end
                ST_STOP: if (bit_end) begin
                    RXDAT      <= shreg;
                    RXPE       <= pe_pend;
                    RXFE       <= !RXD_VOTE;
                    RXBI       <= shreg == 8'd0 && !(pen_q && par_bit) && !RXD_VOTE;
                    RXFINISHED <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_framer.sv
// tb_uart_rx_framer: directed and randomized frames against a behavioural frame model
module tb_uart_rx_framer;
    typedef struct {
        logic [7:0] dat;
        logic       pe;
        logic       fe;
        logic       bi;
        int         tick;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RSTN = 1'b0;
    logic       BAUDCE = 1'b0;
    logic       RXD_RAW = 1'b1;
    logic       RXD_VOTE;
    logic       FILTER_SAMPLE;
    logic       FILTER_CLEAR;
    logic [1:0] WLS = 2'b11;
    logic       PEN = 1'b0;
    logic       EPS = 1'b0;
    logic       SP = 1'b0;
    logic [7:0] RXDAT;
    logic       RXPE;
    logic       RXFE;
    logic       RXBI;
    logic       RXFINISHED;

    int errors = 0;
    int checks = 0;
    int tick_no = 0;
    int clr_cnt = 0;
    int samp_cnt = 0;
    int strobes = 0;
    int cap_tick = 0;
    logic [7:0] cap_dat = '0;
    logic cap_pe = 1'b0, cap_fe = 1'b0, cap_bi = 1'b0;
    logic [7:0] last_dat = '0;
    logic last_pe = 1'b0, last_fe = 1'b0, last_bi = 1'b0;
    exp_t exp_q[$];
    exp_t e;
    int f_ones = 0;
    int f_n = 0;

    uart_rx_framer dut (
        .CLK          (CLK),
        .RSTN         (RSTN),
        .BAUDCE       (BAUDCE),
        .RXD_RAW      (RXD_RAW),
        .RXD_VOTE     (RXD_VOTE),
        .FILTER_SAMPLE(FILTER_SAMPLE),
        .FILTER_CLEAR (FILTER_CLEAR),
        .WLS          (WLS),
        .PEN          (PEN),
        .EPS          (EPS),
        .SP           (SP),
        .RXDAT        (RXDAT),
        .RXPE         (RXPE),
        .RXFE         (RXFE),
        .RXBI         (RXBI),
        .RXFINISHED   (RXFINISHED)
    );

    always #5 CLK = ~CLK;

    // Majority-vote filter stand-in driven by the framer's SAMPLE/CLEAR
    always @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            f_ones <= 0;
            f_n    <= 0;
        end else if (FILTER_CLEAR) begin
            f_ones <= 0;
            f_n    <= 0;
        end else if (FILTER_SAMPLE) begin
            f_ones <= f_ones + (RXD_RAW ? 1 : 0);
            f_n    <= f_n + 1;
        end
    end
    assign RXD_VOTE = 2 * f_ones > f_n;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] w, input logic p, input logic ev,
                                   input logic s, input logic [7:0] d, input logic pb,
                                   input logic st, input int t0);
        exp_t r;
        int n = 5 + int'(w);
        int ones;
        logic want;
        r.dat = d & 8'((1 << n) - 1);
        ones  = $countones(r.dat);
        want  = s ? !ev : (ev ? (ones % 2 == 1) : (ones % 2 == 0));
        r.pe  = p && (pb != want);
        r.fe  = !st;
        r.bi  = (r.dat == 8'd0) && !(p && pb) && !st;
        r.tick = t0 + 16 * (n + int'(p) + 2) + 1;
        return r;
    endfunction

    always @(negedge CLK) begin
        if (!RSTN) begin
            last_dat = '0;
            last_pe  = 1'b0;
            last_fe  = 1'b0;
            last_bi  = 1'b0;
        end else begin
            if (FILTER_CLEAR) clr_cnt++;
            if (FILTER_SAMPLE) samp_cnt++;
            if (RXFINISHED) begin
                strobes++;
                cap_dat  = RXDAT;
                cap_pe   = RXPE;
                cap_fe   = RXFE;
                cap_bi   = RXBI;
                cap_tick = tick_no;
                chk("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("rxdat", 32'(RXDAT), 32'(e.dat));
                    chk("rxpe", 32'(RXPE), 32'(e.pe));
                    chk("rxfe", 32'(RXFE), 32'(e.fe));
                    chk("rxbi", 32'(RXBI), 32'(e.bi));
                    chk("strobe_tick", 32'(tick_no), 32'(e.tick));
                    last_dat = e.dat;
                    last_pe  = e.pe;
                    last_fe  = e.fe;
                    last_bi  = e.bi;
                end
            end else
                chk("hold", 32'({RXDAT, RXPE, RXFE, RXBI}), 32'({last_dat, last_pe, last_fe, last_bi}));
        end
    end

    task automatic tick(input logic v);
        RXD_RAW = v;
        BAUDCE  = 1'b1;
        @(posedge CLK);
        #1;
        BAUDCE = 1'b0;
        tick_no++;
        repeat ($urandom_range(1, 3)) @(posedge CLK);
        #1;
    endtask

    task automatic bits(input logic v, input int k);
        for (int i = 0; i < k; i++) tick(v);
    endtask

    task automatic send_frame(input logic [1:0] w, input logic p, input logic ev, input logic s,
                              input logic [7:0] d, input logic pb, input logic st, input logic chg);
        int n = 5 + int'(w);
        WLS = w;
        PEN = p;
        EPS = ev;
        SP  = s;
        exp_q.push_back(model(w, p, ev, s, d, pb, st, tick_no));
        bits(1'b0, 16);
        if (chg) begin
            WLS = 2'($urandom);
            PEN = 1'($urandom);
            EPS = 1'($urandom);
            SP  = 1'($urandom);
        end
        for (int i = 0; i < n; i++) bits(d[i], 16);
        if (p) bits(pb, 16);
        bits(st, 16);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_rxdat"}, 32'(RXDAT), 32'd0);
        chk({tag, "_rxpe"}, 32'(RXPE), 32'd0);
        chk({tag, "_rxfe"}, 32'(RXFE), 32'd0);
        chk({tag, "_rxbi"}, 32'(RXBI), 32'd0);
        chk({tag, "_rxfinished"}, 32'(RXFINISHED), 32'd0);
        chk({tag, "_filter_clear"}, 32'(FILTER_CLEAR), 32'd0);
        chk({tag, "_filter_sample"}, 32'(FILTER_SAMPLE), 32'd0);
    endtask

    initial begin
        int s0, n0, c0, sm0;
        logic [7:0] d;
        RXD_RAW = 1'b0;
        BAUDCE  = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk_zero_outputs("reset");
        BAUDCE  = 1'b0;
        RXD_RAW = 1'b1;
        @(posedge CLK);
        #2 RSTN = 1'b1;
        @(posedge CLK);
        #1;
        bits(1'b1, 4);

        s0 = tick_no;
        n0 = strobes;
        send_frame(2'b11, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0);
        tick(1'b1);
        chk("a5_strobes", 32'(strobes - n0), 32'd1);
        chk("a5_dat", 32'(cap_dat), 32'hA5);
        chk("a5_flags", 32'({cap_pe, cap_fe, cap_bi}), 32'd0);
        chk("a5_latency", 32'(cap_tick - s0), 32'd161);
        bits(1'b1, 3);

        send_frame(2'b00, 1'b1, 1'b1, 1'b0, 8'h13, 1'b0, 1'b1, 1'b0);
        tick(1'b1);
        chk("5e1_dat", 32'(cap_dat), 32'h13);
        chk("5e1_pe", 32'(cap_pe), 32'd1);
        chk("5e1_fe", 32'(cap_fe), 32'd0);
        bits(1'b1, 3);

        n0 = strobes;
        send_frame(2'b11, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tick(1'b0);
        chk("brk_strobes", 32'(strobes - n0), 32'd1);
        chk("brk_dat", 32'(cap_dat), 32'h00);
        chk("brk_fe", 32'(cap_fe), 32'd1);
        chk("brk_bi", 32'(cap_bi), 32'd1);
        c0  = clr_cnt;
        sm0 = samp_cnt;
        n0  = strobes;
        tick(1'b0);
        bits(1'b1, 16);
        bits(1'b1, 3);
        chk("rearm_clears", 32'(clr_cnt - c0), 32'd2);
        chk("rearm_samples", 32'(samp_cnt - sm0), 32'd16);
        chk("rearm_strobes", 32'(strobes - n0), 32'd0);

        c0  = clr_cnt;
        sm0 = samp_cnt;
        n0  = strobes;
        bits(1'b0, 4);
        bits(1'b1, 20);
        chk("glitch_clears", 32'(clr_cnt - c0), 32'd2);
        chk("glitch_samples", 32'(samp_cnt - sm0), 32'd16);
        chk("glitch_strobes", 32'(strobes - n0), 32'd0);

        send_frame(2'b10, 1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
        tick(1'b1);
        chk("stick1_dat", 32'(cap_dat), 32'h55);
        chk("stick1_pe", 32'(cap_pe), 32'd0);
        bits(1'b1, 2);
        send_frame(2'b10, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
        tick(1'b1);
        chk("stick0_pe", 32'(cap_pe), 32'd1);
        bits(1'b1, 2);

        n0  = strobes;
        WLS = 2'b11;
        PEN = 1'b0;
        bits(1'b0, 16);
        bits(1'b1, 48 + 8);
        #2 RSTN = 1'b0;
        BAUDCE  = 1'b1;
        RXD_RAW = 1'b0;
        #1;
        chk_zero_outputs("async_rst");
        repeat (3) @(posedge CLK);
        #1;
        BAUDCE  = 1'b0;
        RXD_RAW = 1'b1;
        #2 RSTN = 1'b1;
        @(posedge CLK);
        #1;
        bits(1'b1, 4);
        chk("abort_strobes", 32'(strobes - n0), 32'd0);
        n0 = strobes;
        send_frame(2'b11, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1);
        tick(1'b1);
        chk("3c_strobes", 32'(strobes - n0), 32'd1);
        chk("3c_dat", 32'(cap_dat), 32'h3C);
        bits(1'b1, 2);

        for (int k = 0; k < 40; k++) begin
            d = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            send_frame(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), d,
                       1'($urandom), $urandom_range(0, 5) != 0, 1'($urandom));
            tick(1'b1);
            bits(1'b1, $urandom_range(1, 4));
        end

        repeat (4) @(posedge CLK);
        chk("pending_frames", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
